// File: rtl/nrst_sequencer.sv
// nrst_sequencer: power-on / PLL-lock reset sequencer.
// Releases NUM_OUT active-low reset domains one at a time, DELAY cycles apart,
// after LOCK_FILTER consecutive synchronized-lock-high cycles. A lock loss or a
// soft-reset request reasserts every domain and holds them for HOLD_CYCLES
// before the sequence restarts.
// Optional feature macro: NRST_SEQ_LOCK_TIMEOUT_EN adds LOCK_TIMEOUT and a
// sticky FAULT_O flag raised when WAIT_LOCK waits too long for lock.
module nrst_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int DELAY       = 16,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 32
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
  , parameter int LOCK_TIMEOUT = 1024
`endif
) (
  input  logic               CLK_I,
  input  logic               NRST_I,
  input  logic               LOCK_I,
  input  logic               SOFT_RST_I,
  output logic [NUM_OUT-1:0] NRST_O,
  output logic               READY_O,
  output logic               BUSY_O
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
  , output logic             FAULT_O
`endif
);

  // One counter is shared by the lock filter, the release spacing and the
  // hold time, so it is sized for the largest of the three.
  localparam int CNT_MAX =
    (DELAY > LOCK_FILTER) ? ((DELAY > HOLD_CYCLES) ? DELAY : HOLD_CYCLES)
                          : ((LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int IW = $clog2(NUM_OUT + 1);
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    RELEASE,
    RUN,
    HOLD
  } state_t;

  logic          rst_meta;
  logic          rst_n;
  logic          lock_meta;
  logic          lock_s;
  logic          abort;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
  logic [TW-1:0] tcnt;
`endif

  // Reset synchronizer: asserts asynchronously, releases on the 2nd CLK_I edge.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the old values,
      // which is what makes this a two-stage shift register and not one flop.
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // Lock synchronizer: LOCK_I is asynchronous to CLK_I.
  always_ff @(posedge CLK_I or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= LOCK_I;
      lock_s    <= lock_meta;
    end
  end

  // Abort request seen by RELEASE and RUN; it takes priority over a release.
  assign abort = !lock_s || SOFT_RST_I;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK_I or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      NRST_O  <= '0;
      READY_O <= 1'b0;
      BUSY_O  <= 1'b0;
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
      tcnt    <= '0;
      FAULT_O <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state  <= WAIT_LOCK;
          BUSY_O <= 1'b1;
          cnt    <= '0;
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
          tcnt   <= '0;
`endif
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            if (cnt == CW'(LOCK_FILTER - 1)) begin
              state <= RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
          // A soft reset rearms the timeout as well as clearing the flag.
          if (SOFT_RST_I) begin
            tcnt <= '0;
          end else if (!(lock_s && cnt == CW'(LOCK_FILTER - 1))) begin
            if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
              FAULT_O <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif
        end

        RELEASE, RUN: begin
          if (abort) begin
            state   <= HOLD;
            cnt     <= '0;
            NRST_O  <= '0;
            READY_O <= 1'b0;
            BUSY_O  <= 1'b1;
          end else if (state == RELEASE) begin
            if (cnt == CW'(DELAY - 1)) begin
              // Shifting a one in keeps NRST_O a thermometer code, low bit first.
              NRST_O <= (NRST_O << 1) | NUM_OUT'(1);
              cnt    <= '0;
              idx    <= idx + 1'b1;
              if (idx == IW'(NUM_OUT - 1)) begin
                state   <= RUN;
                READY_O <= 1'b1;
                BUSY_O  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (SOFT_RST_I) begin
            cnt <= '0;
          end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          NRST_O  <= '0;
          READY_O <= 1'b0;
          BUSY_O  <= 1'b0;
        end
      endcase
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
      // The fault flag is sticky until a soft reset, in any state.
      if (SOFT_RST_I) begin
        FAULT_O <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nrst_sequencer.sv
// tb_nrst_sequencer: directed self-checking bench for nrst_sequencer with
// NUM_OUT=4, DELAY=4, LOCK_FILTER=8, HOLD_CYCLES=6 and a 4 ns clock.
// Edge numbers in comments count CLK_I rising edges from the step's origin.
module tb_nrst_sequencer;

  logic       CLK_I;
  logic       NRST_I;
  logic       LOCK_I;
  logic       SOFT_RST_I;
  logic [3:0] NRST_O;
  logic       READY_O;
  logic       BUSY_O;
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
  logic       FAULT_O;
`endif

  int checks = 0;
  int errors = 0;

  nrst_sequencer #(
    .NUM_OUT     (4),
    .DELAY       (4),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (6)
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
    , .LOCK_TIMEOUT (20)
`endif
  ) dut (
    .CLK_I      (CLK_I),
    .NRST_I     (NRST_I),
    .LOCK_I     (LOCK_I),
    .SOFT_RST_I (SOFT_RST_I),
    .NRST_O     (NRST_O),
    .READY_O    (READY_O),
    .BUSY_O     (BUSY_O)
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
    , .FAULT_O  (FAULT_O)
`endif
  );

  initial CLK_I = 1'b0;
  always #2 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] n, input logic r, input logic b);
    check({tag, " nrst"},  32'(NRST_O),  32'(n));
    check({tag, " ready"}, 32'(READY_O), 32'(r));
    check({tag, " busy"},  32'(BUSY_O),  32'(b));
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  // Full power-up sequence, starting 1 ns after NRST_I rose with LOCK_I high.
  // e2: reset still held inside; e3: IDLE->WAIT_LOCK; e4: LOCK_S high;
  // e5..e11 filter 1..7; e12 RELEASE; releases at e16, e20, e24, e28.
  task automatic power_up(input string tag);
    tick(2);
    check_out({tag, " e2 sync latency"}, 4'b0000, 1'b0, 1'b0);
    tick(1);
    check_out({tag, " e3 wait_lock"}, 4'b0000, 1'b0, 1'b1);
    tick(12);
    check_out({tag, " e15"}, 4'b0000, 1'b0, 1'b1);
    tick(1);
    check_out({tag, " e16"}, 4'b0001, 1'b0, 1'b1);
    tick(3);
    check_out({tag, " e19"}, 4'b0001, 1'b0, 1'b1);
    tick(1);
    check_out({tag, " e20"}, 4'b0011, 1'b0, 1'b1);
    tick(4);
    check_out({tag, " e24"}, 4'b0111, 1'b0, 1'b1);
    tick(3);
    check_out({tag, " e27"}, 4'b0111, 1'b0, 1'b1);
    tick(1);
    check_out({tag, " e28 run"}, 4'b1111, 1'b1, 1'b0);
  endtask

  initial begin
    NRST_I     = 1'b0;
    LOCK_I     = 1'b1;
    SOFT_RST_I = 1'b0;

    // Reset values while NRST_I is low.
    #1;
    check_out("reset t0", 4'b0000, 1'b0, 1'b0);
`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
    check("reset fault", 32'(FAULT_O), 32'h0);
`endif
    tick(3);
    check_out("reset held", 4'b0000, 1'b0, 1'b0);

    // 1. Power-up with lock present throughout.
    NRST_I = 1'b1;
    power_up("pwr");

    // 3. Lock loss in RUN. LOCK_S falls at a2, abort on a3; LOCK_I comes back
    //    during HOLD and must be ignored. HOLD a3..a8, WAIT_LOCK at a9,
    //    RELEASE at a17, releases at a21/25/29/33.
    LOCK_I = 1'b0;
    tick(2);
    check_out("loss a2", 4'b1111, 1'b1, 1'b0);
    LOCK_I = 1'b1;
    tick(1);
    check_out("loss a3 abort", 4'b0000, 1'b0, 1'b1);
    tick(6);
    check_out("loss a9", 4'b0000, 1'b0, 1'b1);
    tick(11);
    check_out("loss a20", 4'b0000, 1'b0, 1'b1);
    tick(1);
    check_out("loss a21", 4'b0001, 1'b0, 1'b1);
    tick(4);
    check_out("loss a25", 4'b0011, 1'b0, 1'b1);
    tick(4);
    check_out("loss a29", 4'b0111, 1'b0, 1'b1);
    tick(4);
    check_out("loss a33", 4'b1111, 1'b1, 1'b0);

    // 2. Glitchy lock. Soft reset from RUN, lock low through HOLD (b1..b6),
    //    WAIT_LOCK at b7. Then lock high 5, low 1, high: filter reaches 5,
    //    clears at c8, refills c9..c15, RELEASE c16, first release c20.
    SOFT_RST_I = 1'b1;
    tick(1);
    check_out("glitch b1 abort", 4'b0000, 1'b0, 1'b1);
    SOFT_RST_I = 1'b0;
    LOCK_I     = 1'b0;
    tick(6);
    LOCK_I = 1'b1;
    tick(5);
    LOCK_I = 1'b0;
    tick(1);
    LOCK_I = 1'b1;
    tick(13);
    check_out("glitch c19", 4'b0000, 1'b0, 1'b1);
    tick(1);
    check_out("glitch c20", 4'b0001, 1'b0, 1'b1);

    // 4. Soft pulse at NRST_O=0011, second pulse 3 cycles into HOLD (d4).
    //    HOLD exits at d10, RELEASE d18, first release d22.
    tick(3);
    check_out("soft c23", 4'b0001, 1'b0, 1'b1);
    tick(1);
    check_out("soft c24", 4'b0011, 1'b0, 1'b1);
    SOFT_RST_I = 1'b1;
    tick(1);
    check_out("soft d1 abort", 4'b0000, 1'b0, 1'b1);
    SOFT_RST_I = 1'b0;
    tick(2);
    SOFT_RST_I = 1'b1;
    tick(1);
    SOFT_RST_I = 1'b0;
    tick(5);
    check_out("soft d9 hold", 4'b0000, 1'b0, 1'b1);
    tick(12);
    check_out("soft d21", 4'b0000, 1'b0, 1'b1);
    tick(1);
    check_out("soft d22", 4'b0001, 1'b0, 1'b1);

    // 5. Asynchronous NRST_I mid-RELEASE, away from any clock edge.
    tick(4);
    check_out("async d26", 4'b0011, 1'b0, 1'b1);
    #1;
    NRST_I = 1'b0;
    #1;
    check_out("async immediate", 4'b0000, 1'b0, 1'b0);
    tick(2);
    check_out("async held", 4'b0000, 1'b0, 1'b0);
    NRST_I = 1'b1;
    power_up("repwr");

`ifdef NRST_SEQ_LOCK_TIMEOUT_EN
    // 6. Lock lost for good: HOLD f3..f8, WAIT_LOCK at f9, fault at f29.
    LOCK_I = 1'b0;
    tick(3);
    check_out("tmo f3 abort", 4'b0000, 1'b0, 1'b1);
    tick(6);
    tick(19);
    check("tmo f28 fault", 32'(FAULT_O), 32'h0);
    tick(1);
    check("tmo f29 fault", 32'(FAULT_O), 32'h1);
    check_out("tmo f29", 4'b0000, 1'b0, 1'b1);
    SOFT_RST_I = 1'b1;
    tick(1);
    check("tmo soft clear", 32'(FAULT_O), 32'h0);
    SOFT_RST_I = 1'b0;
    tick(3);
    check("tmo still clear", 32'(FAULT_O), 32'h0);
    check_out("tmo waiting", 4'b0000, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
